// File: rtl/l2_coherent_responder.sv
// Shared L2 responder: round-robin arbitration across L1 ports, snoop-invalidate
// broadcast for writes, fixed-latency access to an internal word memory.
module l2_coherent_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NCORES        = 2,
    parameter int MEM_WORDS     = 4096,
    parameter int MISS_PENALTY  = 8,
    parameter int SNOOP_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NCORES-1:0]            l2_req_valid,
    input  logic [NCORES-1:0]            l2_req_wr,
    input  logic [NCORES*ADDR_WIDTH-1:0] l2_req_addr,
    input  logic [NCORES*DATA_WIDTH-1:0] l2_req_wdata,
    output logic [NCORES-1:0]            l2_resp_valid,
    output logic [DATA_WIDTH-1:0]        l2_resp_rdata,
    output logic                         snoop_valid,
    output logic [ADDR_WIDTH-1:0]        snoop_addr,
    output logic [1:0]                   snoop_source_id,
    input  logic [NCORES-1:0]            snoop_ack,
    output logic                         busy,
    output logic [1:0]                   grant_id,
    output logic                         snoop_timeout_err,
    output logic [1:0]                   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNOOP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [3:0]  CORE_MASK = 4'((1 << NCORES) - 1);
    localparam logic [15:0] ACC_INIT  = 16'(MISS_PENALTY - 1);
    localparam logic [15:0] SNP_LIMIT = 16'(SNOOP_TIMEOUT);

    state_t                  r_state;
    logic [1:0]              r_ptr;
    logic [1:0]              r_gid;
    logic                    r_wr;
    logic [IDX_W-1:0]        r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [ADDR_WIDTH-1:0]   r_saddr;
    logic [15:0]             r_cnt;
    logic [3:0]              r_acks;
    logic [NCORES-1:0]       r_resp;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_snoop_valid;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS] = '{default: '0};

    // Per-core views padded to four slots so a 2-bit core index always fits.
    logic [3:0]              w_req4;
    logic [3:0]              w_wr4;
    logic [3:0]              w_ack4;
    logic [ADDR_WIDTH-1:0]   w_addr  [4];
    logic [DATA_WIDTH-1:0]   w_wdata [4];
    logic [1:0]              w_cand;
    logic [1:0]              w_gnt;
    logic                    w_found;
    logic [3:0]              w_need;
    logic                    w_acked;
    logic                    w_commit;

    assign w_req4 = 4'(l2_req_valid);
    assign w_wr4  = 4'(l2_req_wr);
    assign w_ack4 = 4'(snoop_ack);

    for (genvar c = 0; c < 4; c++) begin : g_unpack
        if (c < NCORES) begin : g_core
            assign w_addr[c]  = l2_req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[c] = l2_req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign w_addr[c]  = '0;
            assign w_wdata[c] = '0;
        end
    end

    // First requester at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_ptr;
        w_cand  = '0;
        for (int i = 0; i < NCORES; i++) begin
            w_cand = 2'((int'(r_ptr) + i) % NCORES);
            if (!w_found && w_req4[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_need   = CORE_MASK & ~(4'b0001 << r_gid);
    assign w_acked  = ((w_need & ~(r_acks | w_ack4)) == 4'b0000);
    assign w_commit = (r_state == ST_ACCESS) && (r_cnt == 16'd0) && r_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_gid         <= '0;
            r_wr          <= 1'b0;
            r_idx         <= '0;
            r_wdata       <= '0;
            r_saddr       <= '0;
            r_cnt         <= '0;
            r_acks        <= '0;
            r_resp        <= '0;
            r_rdata       <= '0;
            r_snoop_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gid   <= w_gnt;
                        r_ptr   <= 2'((int'(w_gnt) + 1) % NCORES);
                        r_wr    <= w_wr4[w_gnt];
                        r_idx   <= w_addr[w_gnt][2 +: IDX_W];
                        r_wdata <= w_wdata[w_gnt];
                        r_acks  <= '0;
                        if (w_wr4[w_gnt]) begin
                            r_saddr       <= w_addr[w_gnt];
                            r_snoop_valid <= 1'b1;
                            r_cnt         <= 16'd1;
                            r_state       <= ST_SNOOP;
                        end else begin
                            r_cnt   <= ACC_INIT;
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_SNOOP: begin
                    r_acks <= r_acks | w_ack4;
                    if (w_acked || (r_cnt == SNP_LIMIT)) begin
                        if (!w_acked) begin
                            r_err <= 1'b1;
                        end
                        r_snoop_valid <= 1'b0;
                        r_cnt         <= ACC_INIT;
                        r_state       <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 16'd0) begin
                        r_rdata <= r_wr ? r_wdata : r_mem[r_idx];
                        for (int c = 0; c < NCORES; c++) begin
                            r_resp[c] <= (r_gid == 2'(c));
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_RESP: begin
                    r_resp  <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Backing store is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign l2_resp_valid     = r_resp;
    assign l2_resp_rdata     = r_rdata;
    assign snoop_valid       = r_snoop_valid;
    assign snoop_addr        = r_saddr;
    assign snoop_source_id   = r_gid;
    assign busy              = (r_state != ST_IDLE);
    assign grant_id          = r_gid;
    assign snoop_timeout_err = r_err;
    assign dbg_state         = r_state;

endmodule
